// File: rtl/ft_pkg.sv
// Shared types and constants for the FT600 transmit-side blocks.
package ft_pkg;

  typedef enum logic [1:0] {
    PAT_CNT   = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_WALK  = 2'd2,
    PAT_CONST = 2'd3
  } pat_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_BURST = 2'd2,
    S_GAP   = 2'd3
  } txgen_state_t;

  localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h0000_B400;

endpackage

// File: rtl/ft_tx_pattern_gen_pattern_next.sv
// Pure next-pattern function for the test-data generator; shared with any checker
// that needs to predict the stream.
module pattern_next
  import ft_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter logic [31:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
  input  pat_mode_t         i_mode,
  input  logic [DATA_W-1:0] i_pat,
  output logic [DATA_W-1:0] o_pat_next
);

  localparam logic [DATA_W-1:0] POLY = LFSR_POLY[DATA_W-1:0];

  always_comb begin
    o_pat_next = i_pat;
    case (i_mode)
      PAT_CNT:   o_pat_next = i_pat + DATA_W'(1);
      // Galois form: a zero state is unreachable as long as the seed is nonzero.
      PAT_LFSR:  o_pat_next = i_pat[0] ? ((i_pat >> 1) ^ POLY) : (i_pat >> 1);
      PAT_WALK:  o_pat_next = {i_pat[DATA_W-2:0], i_pat[DATA_W-1]};
      PAT_CONST: o_pat_next = i_pat;
      default:   o_pat_next = i_pat;
    endcase
  end

endmodule

// File: rtl/ft_tx_pattern_gen.sv
// Burst/gap test-data source for the FT600 write path with selectable pattern,
// FIFO backpressure, sent-word counter and status LEDs.
module ft_tx_pattern_gen
  import ft_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          LEN_W     = 16,
  parameter int          GAP_W     = 8,
  parameter logic [31:0] LFSR_POLY = LFSR_POLY_DEFAULT,
  localparam int         BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_seed,
  input  logic [LEN_W-1:0]  i_burst_len,
  input  logic [GAP_W-1:0]  i_gap_len,
  input  logic              i_full,
  input  logic              i_rst_busy,
  output logic [DATA_W-1:0] o_din,
  output logic [BE_W-1:0]   o_din_valid,
  output logic              o_busy,
  output logic [31:0]       o_words_sent,
  output logic [7:0]        o_led
);

  txgen_state_t      r_state;
  pat_mode_t         r_mode;
  logic [LEN_W-1:0]  r_burst_len;
  logic [GAP_W-1:0]  r_gap_len;
  logic [LEN_W-1:0]  r_burst_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [DATA_W-1:0] r_pat;
  logic [DATA_W-1:0] r_din;
  logic [BE_W-1:0]   r_din_valid;
  logic [31:0]       r_words;
  logic [7:0]        r_led;

  logic              w_issue;
  logic              w_stall;
  logic              w_seed_zero_bad;
  logic [DATA_W-1:0] w_seed;
  logic [DATA_W-1:0] w_pat_next;

  assign w_issue = (r_state == S_BURST) && i_enable && !i_full && !i_rst_busy;
  assign w_stall = (r_state == S_BURST) && (i_full || i_rst_busy);

  // LFSR and walking-one would lock up on an all-zero seed.
  assign w_seed_zero_bad = (i_seed == '0) &&
                           ((pat_mode_t'(i_mode) == PAT_LFSR) || (pat_mode_t'(i_mode) == PAT_WALK));
  assign w_seed = w_seed_zero_bad ? DATA_W'(1) : i_seed;

  pattern_next #(
    .DATA_W   (DATA_W),
    .LFSR_POLY(LFSR_POLY)
  ) u_pattern_next (
    .i_mode    (r_mode),
    .i_pat     (r_pat),
    .o_pat_next(w_pat_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= PAT_CNT;
      r_burst_len <= '0;
      r_gap_len   <= '0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
      r_pat       <= '0;
      r_din       <= '0;
      r_din_valid <= '0;
      r_words     <= '0;
      r_led       <= 8'h01;
    end else begin
      r_din_valid <= '0;
      r_led       <= {r_state, r_mode, w_stall, i_rst_busy, (r_state != S_IDLE), 1'b1};
      if (!i_enable) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_LOAD;
          S_LOAD: begin
            r_mode      <= pat_mode_t'(i_mode);
            r_burst_len <= i_burst_len;
            r_gap_len   <= i_gap_len;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_pat       <= w_seed;
            r_state     <= S_BURST;
          end
          S_BURST: begin
            if (w_issue) begin
              r_din       <= r_pat;
              r_din_valid <= '1;
              r_pat       <= w_pat_next;
              r_words     <= r_words + 32'd1;
              // A zero burst length means one endless burst.
              if (r_burst_len != '0) begin
                if (r_burst_cnt == r_burst_len - LEN_W'(1)) begin
                  r_burst_cnt <= '0;
                  if (r_gap_len != '0) r_state <= S_GAP;
                end else begin
                  r_burst_cnt <= r_burst_cnt + LEN_W'(1);
                end
              end
            end
          end
          S_GAP: begin
            if (r_gap_cnt == r_gap_len - GAP_W'(1)) begin
              r_gap_cnt <= '0;
              r_state   <= S_BURST;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_din        = r_din;
  assign o_din_valid  = r_din_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_words_sent = r_words;
  assign o_led        = r_led;

endmodule

// File: tb/tb_ft_tx_pattern_gen.sv
// Directed self-checking bench for ft_tx_pattern_gen: patterns, bursts/gaps,
// backpressure, enable drop and reset.
module tb_ft_tx_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic [15:0] burstLen;
  logic [7:0]  gapLen;
  logic        full;
  logic        rstBusy;
  logic [15:0] din;
  logic [1:0]  dinValid;
  logic        busy;
  logic [31:0] wordsSent;
  logic [7:0]  led;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  ft_tx_pattern_gen dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (enable),
    .i_mode      (mode),
    .i_seed      (seed),
    .i_burst_len (burstLen),
    .i_gap_len   (gapLen),
    .i_full      (full),
    .i_rst_busy  (rstBusy),
    .o_din       (din),
    .o_din_valid (dinValid),
    .o_busy      (busy),
    .o_words_sent(wordsSent),
    .o_led       (led)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge, once registers have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    enable = 1'b0;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] s,
                               input logic [15:0] bl, input logic [7:0] gl);
    mode     = m;
    seed     = s;
    burstLen = bl;
    gapLen   = gl;
    enable   = 1'b1;
  endtask

  task automatic expectWord(input string tag, input logic [15:0] val);
    tick();
    checkOutput({tag, " valid"}, 32'(dinValid), 32'h3);
    checkOutput({tag, " din"}, 32'(din), 32'(val));
  endtask

  task automatic expectIdle(input string tag);
    tick();
    checkOutput({tag, " valid"}, 32'(dinValid), 32'h0);
  endtask

  function automatic logic [15:0] lfsrNext(input logic [15:0] p);
    return p[0] ? ((p >> 1) ^ 16'hB400) : (p >> 1);
  endfunction

  initial begin
    logic [15:0] p;
    int          loopErr;
    int          zeroSeen;

    rst = 1'b1; enable = 1'b0; mode = 2'd0; seed = '0; burstLen = '0; gapLen = '0;
    full = 1'b0; rstBusy = 1'b0;
    tick();
    tick();
    checkOutput("reset din", 32'(din), 32'h0);
    checkOutput("reset valid", 32'(dinValid), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset words", wordsSent, 32'h0);
    checkOutput("reset led", 32'(led), 32'h01);
    rst = 1'b0;

    // Counter wrap, continuous burst.
    applyStimulus(2'd0, 16'hFFFE, 16'd0, 8'd0);
    tick();
    checkOutput("load busy", 32'(busy), 32'h1);
    checkOutput("load valid", 32'(dinValid), 32'h0);
    tick();
    checkOutput("burst entry valid", 32'(dinValid), 32'h0);
    expectWord("cnt w0", 16'hFFFE);
    expectWord("cnt w1", 16'hFFFF);
    expectWord("cnt w2", 16'h0000);
    expectWord("cnt w3", 16'h0001);
    enable = 1'b0;
    expectIdle("cnt stop");
    checkOutput("cnt stop busy", 32'(busy), 32'h0);
    checkOutput("cnt words", wordsSent, 32'd4);
    checkOutput("cnt led", 32'(led), 32'h83);

    // Bursts of 4 separated by 3 idle cycles.
    doReset();
    applyStimulus(2'd0, 16'h0000, 16'd4, 8'd3);
    tick();
    tick();
    for (int i = 0; i < 4; i++) expectWord("burst A", 16'(i));
    for (int i = 0; i < 3; i++) expectIdle("gap");
    for (int i = 4; i < 8; i++) expectWord("burst B", 16'(i));
    enable = 1'b0;
    tick();
    checkOutput("burst words", wordsSent, 32'd8);

    // Backpressure: 5 cycles full, 2 cycles full+rst_busy; config change ignored.
    doReset();
    applyStimulus(2'd0, 16'h0010, 16'd0, 8'd0);
    tick();
    tick();
    expectWord("bp w0", 16'h0010);
    expectWord("bp w1", 16'h0011);
    full = 1'b1;
    mode = 2'd3;
    seed = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      expectIdle("bp full");
      checkOutput("bp full din", 32'(din), 32'h0011);
    end
    checkOutput("bp led stall", 32'(led), 32'h8B);
    rstBusy = 1'b1;
    for (int i = 0; i < 2; i++) expectIdle("bp both");
    full = 1'b0;
    rstBusy = 1'b0;
    expectWord("bp w2", 16'h0012);
    expectWord("bp w3", 16'h0013);
    checkOutput("bp words", wordsSent, 32'd4);

    // Walking-one and constant with short runs.
    doReset();
    applyStimulus(2'd2, 16'h0000, 16'd0, 8'd0);
    tick();
    tick();
    expectWord("walk w0", 16'h0001);
    expectWord("walk w1", 16'h0002);
    expectWord("walk w2", 16'h0004);
    doReset();
    applyStimulus(2'd3, 16'h005A, 16'd0, 8'd0);
    tick();
    tick();
    expectWord("const w0", 16'h005A);
    expectWord("const w1", 16'h005A);

    // LFSR full period from seed 0 (forced to 1).
    doReset();
    applyStimulus(2'd1, 16'h0000, 16'd0, 8'd0);
    tick();
    tick();
    expectWord("lfsr w0", 16'h0001);
    expectWord("lfsr w1", 16'hB400);
    p = 16'hB400;
    loopErr = 0;
    zeroSeen = 0;
    for (int i = 2; i < 65535; i++) begin
      p = lfsrNext(p);
      tick();
      if (dinValid !== 2'b11 || din !== p) loopErr++;
      if (din == 16'h0000) zeroSeen++;
    end
    checkOutput("lfsr sequence errors", 32'(loopErr), 32'd0);
    checkOutput("lfsr zero words", 32'(zeroSeen), 32'd0);
    expectWord("lfsr period wrap", 16'h0001);
    checkOutput("lfsr words", wordsSent, 32'h0001_0000);

    // rst_busy held after reset: no words, then first word is the seed.
    doReset();
    rstBusy = 1'b1;
    applyStimulus(2'd0, 16'h1234, 16'd0, 8'd0);
    loopErr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dinValid !== 2'b00) loopErr++;
    end
    checkOutput("rstbusy no words", 32'(loopErr), 32'd0);
    checkOutput("rstbusy led2", 32'(led[2]), 32'h1);
    checkOutput("rstbusy busy", 32'(busy), 32'h1);
    rstBusy = 1'b0;
    expectWord("rstbusy first", 16'h1234);
    expectWord("rstbusy second", 16'h1235);

    // Enable drop mid-burst, restart, then reset mid-burst.
    enable = 1'b0;
    expectIdle("en drop");
    checkOutput("en drop busy", 32'(busy), 32'h0);
    checkOutput("en drop din hold", 32'(din), 32'h1235);
    enable = 1'b1;
    tick();
    tick();
    expectWord("restart w0", 16'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enable = 1'b0;
    checkOutput("midrst din", 32'(din), 32'h0);
    checkOutput("midrst valid", 32'(dinValid), 32'h0);
    checkOutput("midrst busy", 32'(busy), 32'h0);
    checkOutput("midrst words", wordsSent, 32'h0);
    checkOutput("midrst led", 32'(led), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
